// File: rtl/rf_stream_writer_if.sv
// Write-data stream interface for rf_stream_writer.
// The producer (master) drives in_valid_i/in_data_i; the writer (slave)
// answers with in_ready_o. A word moves on a rising edge where both
// in_valid_i and in_ready_o are high.
//   in_valid_i  producer has a word on in_data_i
//   in_data_i   signed data word, DataWidth bits
//   in_ready_o  writer can take a word this cycle
interface rf_stream_writer_if #(
    parameter int unsigned DataWidth = 16
);
    logic                        in_valid_i;
    logic signed [DataWidth-1:0] in_data_i;
    logic                        in_ready_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        output in_ready_o
    );
endinterface

// File: rtl/rf_stream_writer.sv
// rf_stream_writer: fills a latch-based register file from a valid/ready
// data stream.
//
// A job starts in IDLE when start_i is seen. It writes count_i words
// (clamped to NumWords) to consecutive addresses from base_addr_i, wrapping
// modulo NumWords. Each word takes at least three cycles:
//   ACCEPT (take a word) -> WRITE (we_o high) -> HOLD (we_o low).
// Address and data stay stable through WRITE and HOLD, so the latch write
// pulse sees settled inputs on both sides.
//
// Optional feature, macro RF_WRITER_READBACK_EN: after the last word the
// job's addresses are read back one per cycle. err_o is raised if the XOR of
// the words read back differs from the XOR of the words accepted. Without
// the macro raddr_o and err_o are constant 0 and READBACK is never entered.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             start a job (only looked at in IDLE)
//   base_addr_i         first write address, captured with start_i
//   count_i             words to write, 0..NumWords, captured with start_i
//   in_s                write-data stream (slave side)
//   waddr_o/wdata_o/we_o  register-file write port, all registered
//   raddr_o/rdata_i     register-file read port (combinational read)
//   busy_o              high in every state except IDLE
//   done_o              one-cycle pulse at job end
//   err_o               readback mismatch, valid with done_o, held to next start
module rf_stream_writer #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [AddrWidth-1:0]        base_addr_i,
    input  logic [AddrWidth:0]          count_i,
    rf_stream_writer_if.slave           in_s,
    output logic [AddrWidth-1:0]        waddr_o,
    output logic signed [DataWidth-1:0] wdata_o,
    output logic                        we_o,
    output logic [AddrWidth-1:0]        raddr_o,
    input  logic signed [DataWidth-1:0] rdata_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int unsigned NumWords = 2 ** AddrWidth;
    localparam int unsigned CntWidth = AddrWidth + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCEPT   = 3'd1,
        WRITE    = 3'd2,
        HOLD     = 3'd3,
        READBACK = 3'd4,
        FINISH   = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic [AddrWidth-1:0]        addr_q, addr_d;
    logic [CntWidth-1:0]         left_q, left_d;
    logic [CntWidth-1:0]         count_clamped;
    logic                        handshake;

    logic [AddrWidth-1:0]        waddr_d;
    logic signed [DataWidth-1:0] wdata_d;
    logic                        we_d;
    logic                        ready_d;
    logic                        busy_d;
    logic                        done_d;
    logic                        err_d;

`ifdef RF_WRITER_READBACK_EN
    logic [AddrWidth-1:0]        base_q, base_d;
    logic [CntWidth-1:0]         total_q, total_d;
    logic [AddrWidth-1:0]        raddr_d;
    logic signed [DataWidth-1:0] wxor_q, wxor_d;
    logic signed [DataWidth-1:0] rxor_q, rxor_d;
`else
    logic                        unused_rdata;
    assign unused_rdata = ^rdata_i;
    assign raddr_o      = '0;
`endif

    // Requests larger than the register file are cut to one full pass.
    assign count_clamped = (count_i > CntWidth'(NumWords)) ? CntWidth'(NumWords) : count_i;

    // in_ready_o is registered high exactly while in ACCEPT.
    assign handshake = in_s.in_valid_i & in_s.in_ready_o;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next datapath values and next registered outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        waddr_d = waddr_o;
        wdata_d = wdata_o;
        we_d    = 1'b0;
        err_d   = err_o;
`ifdef RF_WRITER_READBACK_EN
        base_d  = base_q;
        total_d = total_q;
        raddr_d = raddr_o;
        wxor_d  = wxor_q;
        rxor_d  = rxor_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d  = 1'b0;
                    addr_d = base_addr_i;
                    left_d = count_clamped;
`ifdef RF_WRITER_READBACK_EN
                    base_d  = base_addr_i;
                    total_d = count_clamped;
                    wxor_d  = '0;
                    rxor_d  = '0;
`endif
                    state_d = (count_clamped == '0) ? FINISH : ACCEPT;
                end
            end

            ACCEPT: begin
                // Write address and data only change on this edge.
                if (handshake) begin
                    waddr_d = addr_q;
                    wdata_d = in_s.in_data_i;
                    we_d    = 1'b1;
`ifdef RF_WRITER_READBACK_EN
                    wxor_d  = wxor_q ^ in_s.in_data_i;
`endif
                    state_d = WRITE;
                end
            end

            WRITE: begin
                state_d = HOLD;
            end

            HOLD: begin
                addr_d = addr_q + 1'b1;
                left_d = left_q - 1'b1;
                if (left_q > CntWidth'(1)) begin
                    state_d = ACCEPT;
                end else begin
`ifdef RF_WRITER_READBACK_EN
                    // Reuse the word counter to time the readback pass.
                    raddr_d = base_q;
                    left_d  = total_q;
                    state_d = READBACK;
`else
                    state_d = FINISH;
`endif
                end
            end

            READBACK: begin
`ifdef RF_WRITER_READBACK_EN
                rxor_d  = rxor_q ^ rdata_i;
                raddr_d = raddr_o + 1'b1;
                left_d  = left_q - 1'b1;
                if (left_q == CntWidth'(1)) begin
                    err_d   = (wxor_q != rxor_d);
                    state_d = FINISH;
                end
`else
                state_d = FINISH;
`endif
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        ready_d = (state_d == ACCEPT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q          <= '0;
            left_q          <= '0;
            waddr_o         <= '0;
            wdata_o         <= '0;
            we_o            <= 1'b0;
            in_s.in_ready_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            left_q          <= left_d;
            waddr_o         <= waddr_d;
            wdata_o         <= wdata_d;
            we_o            <= we_d;
            in_s.in_ready_o <= ready_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            err_o           <= err_d;
        end
    end

`ifdef RF_WRITER_READBACK_EN
    // Readback bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q  <= '0;
            total_q <= '0;
            raddr_o <= '0;
            wxor_q  <= '0;
            rxor_q  <= '0;
        end else begin
            base_q  <= base_d;
            total_q <= total_d;
            raddr_o <= raddr_d;
            wxor_q  <= wxor_d;
            rxor_q  <= rxor_d;
        end
    end
`endif

endmodule
